// File: rtl/pulse_sequencer.sv
// pulse_sequencer: programmable burst-pulse controller.
// Latches a period, a pulse width and a pulse count on an accepted start.
// It then drives n_pulses impulses spaced period cycles apart, and reports
// busy while the burst runs and a one-cycle done strobe when it ends.
// Optional feature macro: PULSE_SEQ_ABORT_EN adds the abort input, which
// cuts a running burst short.
module pulse_sequencer #(
    parameter int CNT_W = 8,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef PULSE_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [N_W-1:0]   n_pulses,
    output logic             impulse,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   pulse_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [N_W-1:0]   N_ONE   = N_W'(1);

    state_t           state;
    state_t           state_nxt;

    // Phase counter within the current pulse period
    logic [CNT_W-1:0] ph;
    logic [CNT_W-1:0] ph_nxt;
    logic [N_W-1:0]   idx_nxt;

    // Normalised configuration held for the duration of a burst
    logic [CNT_W-1:0] p_lat;
    logic [CNT_W-1:0] w_lat;
    logic [N_W-1:0]   n_lat;
    logic [CNT_W-1:0] p_nxt;
    logic [CNT_W-1:0] w_nxt;
    logic [N_W-1:0]   n_nxt;

    // Normalised view of the live configuration inputs
    logic [CNT_W-1:0] p_norm;
    logic [CNT_W-1:0] w_floor;
    logic [CNT_W-1:0] w_norm;

    logic             abort_req;
    logic             phase_last;
    logic             pulse_last;

    // Next values of the registered outputs
    logic             impulse_d;
    logic             busy_d;
    logic             done_d;

`ifdef PULSE_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // P = max(period, 1); W = min(max(width, 1), P).
    // W == P keeps the impulse high for the whole burst.
    assign p_norm  = (period == '0) ? CNT_ONE : period;
    assign w_floor = (width == '0) ? CNT_ONE : width;
    assign w_norm  = (w_floor > p_norm) ? p_norm : w_floor;

    // Terminal counts are compared against P-1 and N-1.
    // The counters therefore never step past their limits, so N = 2^N_W-1 works.
    // In RUN both P and N are at least 1, so the subtraction cannot wrap.
    assign phase_last = (ph == (p_lat - CNT_ONE));
    assign pulse_last = (pulse_idx == (n_lat - N_ONE));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and counter/config update logic
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        ph_nxt    = ph;
        idx_nxt   = pulse_idx;
        p_nxt     = p_lat;
        w_nxt     = w_lat;
        n_nxt     = n_lat;

        unique case (state)
            IDLE: begin
                ph_nxt  = '0;
                idx_nxt = '0;
                if (start) begin
                    p_nxt     = p_norm;
                    w_nxt     = w_norm;
                    n_nxt     = n_pulses;
                    state_nxt = (n_pulses == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                if (abort_req) begin
                    // Abort takes priority over the normal last-pulse completion
                    state_nxt = DONE;
                    ph_nxt    = '0;
                    idx_nxt   = '0;
                end else if (phase_last) begin
                    ph_nxt = '0;
                    if (pulse_last) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = pulse_idx + N_ONE;
                    end
                end else begin
                    ph_nxt = ph + CNT_ONE;
                end
            end

            DONE: begin
                // A start here is dropped, not queued
                state_nxt = IDLE;
                ph_nxt    = '0;
                idx_nxt   = '0;
            end

            default: begin
                state_nxt = IDLE;
                ph_nxt    = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Output decode of the upcoming cycle, registered below so outputs are glitch-free
    always_comb begin
        busy_d    = (state_nxt == RUN);
        done_d    = (state_nxt == DONE);
        impulse_d = (state_nxt == RUN) && (ph_nxt < w_nxt);
    end

    // Datapath, latched configuration and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the latched configuration is reset along with the control
            // flops so the terminal-count compares never see unknown values.
            ph        <= '0;
            p_lat     <= '0;
            w_lat     <= '0;
            n_lat     <= '0;
            pulse_idx <= '0;
            impulse   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ph        <= ph_nxt;
            p_lat     <= p_nxt;
            w_lat     <= w_nxt;
            n_lat     <= n_nxt;
            pulse_idx <= idx_nxt;
            impulse   <= impulse_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: self-checking bench for pulse_sequencer.
// Expected outputs come from a per-cycle arithmetic model of a burst.
// Cycle c after the accepting edge is busy when 1 <= c <= N*P.
// In that range the pulse index is (c-1)/P, and impulse is high when (c-1)%P < W.
// Done is high only in cycle N*P+1.
// Build with PULSE_SEQ_ABORT_EN defined to include the abort checks.
module tb_pulse_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] period = 8'd0;
    logic [7:0] width = 8'd0;
    logic [7:0] n_pulses = 8'd0;
`ifdef PULSE_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       impulse;
    logic       busy;
    logic       done;
    logic [7:0] pulse_idx;

    int tests = 0;
    int failed = 0;

    pulse_sequencer #(.CNT_W(8), .N_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef PULSE_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .period    (period),
        .width     (width),
        .n_pulses  (n_pulses),
        .impulse   (impulse),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    // 10-unit clock; outputs are sampled on the falling edge
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " impulse"}, {31'd0, impulse}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " idx"}, {24'd0, pulse_idx}, 32'd0);
    endtask

    // Reference model: outputs in cycle c (1 = first cycle after the accepting edge)
    task automatic check_cycle(input string tag, input int c, input int p, input int w, input int n);
        int pp, ww, np;
        int e_busy, e_done, e_imp, e_idx;
        pp     = (p < 1) ? 1 : p;
        ww     = (w < 1) ? 1 : w;
        ww     = (ww > pp) ? pp : ww;
        np     = n * pp;
        e_busy = (c >= 1 && c <= np) ? 1 : 0;
        e_done = (c == np + 1) ? 1 : 0;
        e_imp  = (e_busy == 1 && ((c - 1) % pp) < ww) ? 1 : 0;
        e_idx  = (e_busy == 1) ? (c - 1) / pp : 0;
        check($sformatf("%s c=%0d busy", tag, c), {31'd0, busy}, e_busy);
        check($sformatf("%s c=%0d done", tag, c), {31'd0, done}, e_done);
        check($sformatf("%s c=%0d impulse", tag, c), {31'd0, impulse}, e_imp);
        check($sformatf("%s c=%0d idx", tag, c), {24'd0, pulse_idx}, e_idx);
    endtask

    // Must be entered at a falling edge while the DUT is idle. It returns at the falling edge
    // of the first idle cycle after done. hold keeps start high throughout. scramble
    // randomises the configuration inputs while the burst runs.
    task automatic run_burst(input string tag, input int p, input int w, input int n,
                             input bit hold, input bit scramble);
        int np;
        period   = 8'(p);
        width    = 8'(w);
        n_pulses = 8'(n);
        start    = 1'b1;
        np       = ((p < 1) ? 1 : p) * n;
        for (int c = 1; c <= np + 2; c++) begin
            @(negedge clk);
            check_cycle(tag, c, p, w, n);
            if (c <= np + 1 && !hold) begin
                start = 1'($urandom_range(0, 1));
                if (scramble) begin
                    period   = 8'($urandom);
                    width    = 8'($urandom);
                    n_pulses = 8'($urandom);
                end
            end else if (c == np + 2) begin
                start = hold;
            end
        end
    endtask

    initial begin
        // Reset state, and reset beating a simultaneous start
        #1 reset = 1'b1;
        start    = 1'b1;
        period   = 8'd3;
        width    = 8'd1;
        n_pulses = 8'd2;
        #1 check_idle("reset");
        @(negedge clk);
        check_idle("reset+start");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("post reset");

        // Directed bursts
        run_burst("p6w1n3", 6, 1, 3, 1'b0, 1'b1);
        run_burst("p4w4n2", 4, 4, 2, 1'b0, 1'b1);
        run_burst("p0w0n1", 0, 0, 1, 1'b0, 1'b1);
        run_burst("n0", 5, 2, 0, 1'b0, 1'b1);
        run_burst("wclip", 3, 7, 2, 1'b0, 1'b1);

        // Start held high: ignored during the burst, accepted right after idle is reached
        run_burst("restart1", 5, 2, 2, 1'b1, 1'b0);
        run_burst("restart2", 5, 2, 2, 1'b0, 1'b0);

        // Counter limits
        run_burst("nmax", 1, 1, 255, 1'b0, 1'b1);
        run_burst("pmax", 255, 100, 1, 1'b0, 1'b1);

        // Asynchronous reset in cycle 4 of a P=3, N=3 burst
        period   = 8'd3;
        width    = 8'd1;
        n_pulses = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_cycle("rst_mid", 4, 3, 1, 3);
        reset = 1'b1;
        #1 check_idle("rst_mid async");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_idle($sformatf("rst_mid after c=%0d", c));
        end

`ifdef PULSE_SEQ_ABORT_EN
        // Abort in idle is ignored
        abort = 1'b1;
        @(negedge clk);
        check_idle("abort idle");
        abort = 1'b0;

        // Abort in cycle 5 of a P=6, N=3 burst: done in cycle 6, then nothing more
        period   = 8'd6;
        width    = 8'd2;
        n_pulses = 8'd3;
        start    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle("abort", c, 6, 2, 3);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort c=6 done", {31'd0, done}, 32'd1);
        check("abort c=6 busy", {31'd0, busy}, 32'd0);
        check("abort c=6 impulse", {31'd0, impulse}, 32'd0);
        check("abort c=6 idx", {24'd0, pulse_idx}, 32'd0);
        for (int c = 7; c <= 14; c++) begin
            @(negedge clk);
            check_idle($sformatf("abort c=%0d", c));
        end

        // Abort coinciding with the last pulse's final cycle yields a single done
        period   = 8'd2;
        width    = 8'd1;
        n_pulses = 8'd2;
        start    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle("abort_last", c, 2, 1, 2);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_cycle("abort_last", 5, 2, 1, 2);
        @(negedge clk);
        check_idle("abort_last c=6");
`endif

        // Randomised bursts with random start noise and configuration changes mid-burst
        repeat (30) begin
            run_burst("rand", int'($urandom_range(0, 9)), int'($urandom_range(0, 11)),
                      int'($urandom_range(0, 5)), 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Programmable burst-pulse controller for the hw3 timing blocks. On a start request it latches a period, a pulse width and a pulse count, then drives a burst of `n_pulses` impulses spaced `period` cycles apart, reporting busy/done to the requesting logic. It sits between control logic and any block consuming a periodic strobe. It replaces fixed-ratio impulse counters where the ratio, duty and burst length must be set at run time.

## Interface
- `CNT_W`, default 8: width of `period`, `width` and the internal phase counter.
- `N_W`, default 8: width of `n_pulses`, the pulse counter and `pulse_idx`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `period`  in  CNT_W  cycles between pulse rising edges; latched on accepted start.
- `width`  in  CNT_W  impulse high time in cycles; latched on accepted start.
- `n_pulses`  in  N_W  pulses per burst; latched on accepted start.
- `abort`  in  1  terminate the running burst. Present only with `PULSE_SEQ_ABORT_EN`.
- `impulse`  out  1  registered pulse output.
- `busy`  out  1  high while a burst is running.
- `done`  out  1  one-cycle completion strobe.
- `pulse_idx`  out  N_W  index of the current pulse (0..N-1); 0 when not running.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 latches the configuration.
  - Next state is RUN, or DONE if `n_pulses` == 0.
- Configuration is normalised at latch time:
  - P = max(`period`, 1).
  - W = min(max(`width`, 1), P).
  - W == P gives `impulse` continuously high for the whole burst.
- RUN:
  - Phase counter `ph` runs 0..P-1 and wraps to 0.
  - Each wrap increments `pulse_idx`.
  - `impulse` = (`ph` < W).
  - When `ph` == P-1 and `pulse_idx` == N-1, next state is DONE.
- DONE:
  - Lasts exactly one cycle with `done` = 1, `busy` = 0, `impulse` = 0.
  - Then returns to IDLE.
- `start` in RUN or DONE is ignored and is not queued.
- Changes to `period`, `width` or `n_pulses` after an accepted start have no effect until the next accepted start.
- Counter arithmetic:
  - Phase is compared against P-1, never allowed to overflow CNT_W.
  - The pulse counter compares against N-1; the maximum N = 2^N_W - 1 completes correctly.

## Timing
- Reset values, applied immediately (asynchronous): state IDLE, `impulse` 0, `busy` 0, `done` 0, `pulse_idx` 0, latched configuration 0.
- With start accepted at edge T:
  - `busy` = 1 in cycles T+1 .. T+N·P.
  - Pulse k (0-based) is high in cycles T+1+k·P .. T+k·P+W.
  - `pulse_idx` = k throughout cycles T+1+k·P .. T+(k+1)·P.
  - `done` = 1 in cycle T+1+N·P.
  - The earliest next accepted start is the edge ending cycle T+2+N·P, when IDLE is reached.
- N == 0: `done` = 1 in cycle T+1; `busy` and `impulse` never assert.
- Reset asserted mid-burst: all outputs drop in the same cycle and no `done` is produced.
- `start` and `reset` asserted together: reset wins.

## Configuration
- `PULSE_SEQ_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort` = 1 sampled in RUN forces DONE on the next cycle: `impulse` 0, `busy` 0, `done` 1 for one cycle, `pulse_idx` 0.
  - `abort` in IDLE or DONE is ignored.
  - `abort` beats the normal last-pulse completion in the same cycle; only one `done` is produced.
- Not defined:
  - No `abort` port.
  - A burst always runs to completion or until reset.

## Test plan
- P=6, W=1, N=3, start at T:
  - `impulse` high at T+1, T+7, T+13 only.
  - `done` at T+19.
  - `busy` high T+1..T+18.
- P=4, W=4, N=2:
  - `impulse` high continuously T+1..T+8.
  - `done` at T+9.
- P=0, W=0, N=1: behaves as P=1, W=1.
  - `impulse` high at T+1.
  - `done` at T+2.
- N=0: `done` at T+1; `busy` and `impulse` stay 0.
- Re-start held high during a P=5, N=2 burst:
  - The start is ignored and the burst is unchanged.
  - The next burst begins one cycle after the `done` cycle.
- Reset at T+4 of a P=3, N=3 burst: all outputs 0 immediately, no `done`.
- With `PULSE_SEQ_ABORT_EN`: abort at T+5 of a P=6, N=3 burst gives `done` at T+6 and no further impulses.
